regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 26: register width in bits.
REQ-002 SHALL have parameter NREGS, default 13: number of registers.
REQ-003 SHALL have parameter ADDR_W, default 5: address width, where NREGS SHALL NOT exceed 2**ADDR_W.
REQ-004 SHALL have parameter NRD, default 2: number of read ports.
REQ-005 SHALL have parameter ZERO_REG, default 0: when 1, register 0 always reads 0 and ignores writes.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port we_RF, input, 1 bit: write enable.
REQ-009 SHALL have port A3, input, ADDR_W bits: write address.
REQ-010 SHALL have port WD3, input, DATA_W bits: write data.
REQ-011 SHALL have port rd_en, input, NRD bits: per-port read request.
REQ-012 SHALL have port rd_addr, input, NRD x ADDR_W bits: per-port read address.
REQ-013 SHALL have port rd_data, output, NRD x DATA_W bits: registered read data.
REQ-014 SHALL have port rd_valid, output, NRD bits: rd_data is valid and not stale.
REQ-015 SHALL have port claim_en, input, 1 bit: mark the register at claim_addr as pending-write.
REQ-016 SHALL have port claim_addr, input, ADDR_W bits: scoreboard claim address.
REQ-017 SHALL have port busy, output, NREGS bits: scoreboard pending-write bits.
REQ-018 SHALL have port err_oob, output, 1 bit: sticky out-of-range access flag.
REQ-019 SHALL have port registerBank, output, NREGS x DATA_W bits: live contents for debug.

Function
REQ-020 Writes SHALL commit on posedge clk when we_RF=1, A3<NREGS and not (ZERO_REG and A3=0).
REQ-021 Reads SHALL have 1-cycle latency: rd_data[i] and rd_valid[i] are registered from the rd_en and rd_addr values sampled at the edge.
REQ-022 When rd_en[i]=0, rd_data[i] SHALL hold its previous value and rd_valid[i] SHALL be 0.
REQ-023 Bypass: when a same-cycle committing write hits rd_addr[i], rd_data[i] SHALL be WD3, not the old contents.
REQ-024 rd_addr[i]>=NREGS SHALL return data 0 with rd_valid[i]=0 and set err_oob.
REQ-025 A write with A3>=NREGS SHALL be dropped and set err_oob.
REQ-026 A claim with claim_addr>=NREGS SHALL be dropped and set err_oob.
REQ-027 err_oob SHALL stay 1 until reset.
REQ-028 ZERO_REG=1 and address 0 SHALL read 0 with rd_valid=rd_en; busy[0] SHALL never set.
REQ-029 Scoreboard: claim_en sets busy[claim_addr] at the edge; a committing write clears busy[A3] at the edge.
REQ-030 Claim and write to the same address in the same cycle SHALL leave busy set (the new claim wins).
REQ-031 rd_valid[i] SHALL equal rd_en[i] and in-range and (not busy[addr] or same-cycle committing write to addr).
REQ-032 Multiple read ports to the same address SHALL return identical data.
REQ-033 Reads SHALL proceed regardless of we_RF; there is no mutual exclusion between reading and writing.

Reset
REQ-034 rst=0 SHALL asynchronously clear all registers, busy, rd_data, rd_valid and err_oob to 0.
REQ-035 Writes and claims presented in the cycle rst deasserts SHALL be honoured at the first posedge after deassertion.
REQ-036 Reset asserted mid-operation SHALL abort pending claims, leaving no busy bits set.

Structure
REQ-037 The package regfile_pkg SHALL hold default parameter constants and the typedefs for the data word and address.
REQ-038 The scoreboard SHALL be the sub-module regfile_scoreboard (claim/clear logic, busy vector, err contribution).
REQ-039 Read ports SHALL be generated by loop over NRD; no hard-coded port count.

Verification
REQ-040 Write 0x3FFFFFF to reg 5, then read port 0 at reg 5 the next cycle -> rd_data[0]=0x3FFFFFF, rd_valid[0]=1 one cycle later.
REQ-041 Same-cycle write 0x0000AA to reg 7 with both ports reading reg 7 -> both rd_data=0x0000AA next cycle.
REQ-042 Claim reg 3, read reg 3 -> rd_valid=0; write reg 3 while reading -> rd_valid=1 and busy[3]=0.
REQ-043 Claim and write reg 4 in the same cycle -> busy[4]=1 afterwards.
REQ-044 Write to A3=20 (NREGS=13) -> bank unchanged and err_oob=1 sticky; ZERO_REG=1 write 0x55 to reg 0 -> reads 0.
REQ-045 Pulse rst low mid-stream with busy=0x0018 -> all outputs 0 immediately, before any clk edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Default geometry, word/address typedefs and range helper for regfile_mp
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;
  localparam int DEF_DATA_W   = 26;
  localparam int DEF_NREGS    = 13;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NRD      = 2;
  localparam int DEF_ZERO_REG = 0;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned nregs);
    return addr < nregs;
  endfunction
endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Pending-write busy bits; a claim sets, a committing write clears
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_claim_en,
  input  logic [ADDR_W-1:0] i_claim_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  output logic [NREGS-1:0]  o_busy,
  output logic              o_err
);
  logic [NREGS-1:0] r_busy;
  logic             w_claim_in_range;
  logic             w_claim_ok;

  assign w_claim_in_range = addr_in_range(32'(i_claim_addr), NREGS);
  assign w_claim_ok       = i_claim_en && w_claim_in_range &&
                            !((ZERO_REG != 0) && (i_claim_addr == '0));
  assign o_err            = i_claim_en && !w_claim_in_range;

  // Claim is applied after the clear so a same-cycle claim wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NREGS; j++) begin
        if (w_claim_ok && (i_claim_addr == ADDR_W'(j)))
          r_busy[j] <= 1'b1;
        else if (i_clr_en && (i_clr_addr == ADDR_W'(j)))
          r_busy[j] <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module : regfile_mp
// Brief  : Multi-read-port register file with write bypass and busy scoreboard
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_RF,
  input  logic [ADDR_W-1:0]       A3,
  input  logic [DATA_W-1:0]       WD3,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_valid,
  input  logic                    claim_en,
  input  logic [ADDR_W-1:0]       claim_addr,
  output logic [NREGS-1:0]        busy,
  output logic                    err_oob,
  output logic [NREGS*DATA_W-1:0] registerBank
);
  logic [DATA_W-1:0] r_bank [NREGS];
  logic              r_err;
  logic              w_wr_in_range;
  logic              w_wr_commit;
  logic              w_sb_err;
  logic [NRD-1:0]    w_rd_oob;

  assign w_wr_in_range = addr_in_range(32'(A3), NREGS);
  assign w_wr_commit   = we_RF && w_wr_in_range && !((ZERO_REG != 0) && (A3 == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NREGS; j++) r_bank[j] <= '0;
    end else begin
      for (int j = 0; j < NREGS; j++)
        if (w_wr_commit && (A3 == ADDR_W'(j))) r_bank[j] <= WD3;
    end
  end

  generate
    for (genvar j = 0; j < NREGS; j++) begin : g_bank
      assign registerBank[j*DATA_W +: DATA_W] = r_bank[j];
    end
  endgenerate

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_claim_en   (claim_en),
    .i_claim_addr (claim_addr),
    .i_clr_en     (w_wr_commit),
    .i_clr_addr   (A3),
    .o_busy       (busy),
    .o_err        (w_sb_err)
  );

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_in_range;
      logic              w_zero;
      logic              w_hit;
      logic [DATA_W-1:0] w_word;
      logic              w_busy_sel;
      logic [DATA_W-1:0] r_data;
      logic              r_valid;

      assign w_addr     = rd_addr[i*ADDR_W +: ADDR_W];
      assign w_in_range = addr_in_range(32'(w_addr), NREGS);
      assign w_zero     = (ZERO_REG != 0) && (w_addr == '0);
      assign w_hit      = w_wr_commit && (A3 == w_addr);
      assign w_rd_oob[i] = rd_en[i] && !w_in_range;

      always_comb begin
        w_word     = '0;
        w_busy_sel = 1'b0;
        for (int j = 0; j < NREGS; j++) begin
          if (w_addr == ADDR_W'(j)) begin
            w_word     = r_bank[j];
            w_busy_sel = busy[j];
          end
        end
      end

      // Priority: out-of-range, hardwired zero, write bypass, stored contents.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (rd_en[i]) begin
          if (!w_in_range) begin
            r_data  <= '0;
            r_valid <= 1'b0;
          end else if (w_zero) begin
            r_data  <= '0;
            r_valid <= 1'b1;
          end else if (w_hit) begin
            r_data  <= WD3;
            r_valid <= 1'b1;
          end else begin
            r_data  <= w_word;
            r_valid <= !w_busy_sel;
          end
        end else begin
          r_valid <= 1'b0;
        end
      end

      assign rd_data[i*DATA_W +: DATA_W] = r_data;
      assign rd_valid[i]                 = r_valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_sb_err || (we_RF && !w_wr_in_range) || (|w_rd_oob))
      r_err <= 1'b1;
  end

  assign err_oob = r_err;
endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module : tb_regfile_mp
// Brief  : Self-checking bench for regfile_mp (ZERO_REG=0 and ZERO_REG=1 instances)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 26;
  localparam int NR = 13;
  localparam int AW = 5;
  localparam int NP = 2;

  logic           clk;
  logic           rst;
  logic           we_RF;
  logic [AW-1:0]  A3;
  logic [DW-1:0]  WD3;
  logic [NP-1:0]  rd_en;
  logic [NP*AW-1:0] rd_addr;
  logic           claim_en;
  logic [AW-1:0]  claim_addr;

  logic [NP*DW-1:0] rd_data0, rd_data1;
  logic [NP-1:0]    rd_valid0, rd_valid1;
  logic [NR-1:0]    busy0, busy1;
  logic             err0, err1;
  logic [NR*DW-1:0] bank0, bank1;

  logic [NP*DW-1:0] a_rd   [2];
  logic [NP-1:0]    a_rv   [2];
  logic [NR-1:0]    a_busy [2];
  logic             a_err  [2];
  logic [NR*DW-1:0] a_bank [2];

  assign a_rd[0] = rd_data0;   assign a_rd[1] = rd_data1;
  assign a_rv[0] = rd_valid0;  assign a_rv[1] = rd_valid1;
  assign a_busy[0] = busy0;    assign a_busy[1] = busy1;
  assign a_err[0] = err0;      assign a_err[1] = err1;
  assign a_bank[0] = bank0;    assign a_bank[1] = bank1;

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .NRD(NP), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .we_RF(we_RF), .A3(A3), .WD3(WD3),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy(busy0),
    .err_oob(err0), .registerBank(bank0)
  );

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .NRD(NP), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .we_RF(we_RF), .A3(A3), .WD3(WD3),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy(busy1),
    .err_oob(err1), .registerBank(bank1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: index 0 is the ZERO_REG=0 instance, index 1 the ZERO_REG=1 one.
  data_t m_mem  [2][NR];
  bit    m_busy [2][NR];
  bit    m_err  [2];
  data_t m_rd   [2][NP];
  bit    m_rv   [2][NP];

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int j = 0; j < NR; j++) begin
        m_mem[z][j]  = '0;
        m_busy[z][j] = 1'b0;
      end
      for (int i = 0; i < NP; i++) begin
        m_rd[z][i] = '0;
        m_rv[z][i] = 1'b0;
      end
      m_err[z] = 1'b0;
    end
  endtask

  task automatic set_idle();
    we_RF = 1'b0; A3 = '0; WD3 = '0;
    rd_en = '0; rd_addr = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  // Advance the model by the inputs currently presented, then clock the DUTs.
  task automatic tick();
    for (int z = 0; z < 2; z++) begin
      bit commit;
      commit = we_RF && (int'(A3) < NR) && !(z == 1 && A3 == 0);
      for (int i = 0; i < NP; i++) begin
        int a;
        a = int'(rd_addr[i*AW +: AW]);
        if (rd_en[i]) begin
          if (a >= NR) begin
            m_rd[z][i] = '0; m_rv[z][i] = 1'b0; m_err[z] = 1'b1;
          end else if (z == 1 && a == 0) begin
            m_rd[z][i] = '0; m_rv[z][i] = 1'b1;
          end else if (commit && int'(A3) == a) begin
            m_rd[z][i] = WD3; m_rv[z][i] = 1'b1;
          end else begin
            m_rd[z][i] = m_mem[z][a]; m_rv[z][i] = !m_busy[z][a];
          end
        end else begin
          m_rv[z][i] = 1'b0;
        end
      end
      if (we_RF && int'(A3) >= NR) m_err[z] = 1'b1;
      if (claim_en && int'(claim_addr) >= NR) m_err[z] = 1'b1;
      if (commit) begin
        m_mem[z][A3]  = WD3;
        m_busy[z][A3] = 1'b0;
      end
      if (claim_en && int'(claim_addr) < NR && !(z == 1 && claim_addr == 0))
        m_busy[z][claim_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int z = 0; z < 2; z++) begin
      n_cmp++;
      if (a_rd[z] !== '0 || a_rv[z] !== '0) begin
        n_bad++; $display("FAIL reset_rd z=%0d: got data %h valid %b, expected 0", z, a_rd[z], a_rv[z]);
      end
      n_cmp++;
      if (a_busy[z] !== '0 || a_err[z] !== 1'b0) begin
        n_bad++; $display("FAIL reset_busy_err z=%0d: got busy %h err %b, expected 0", z, a_busy[z], a_err[z]);
      end
      n_cmp++;
      if (a_bank[z] !== '0) begin
        n_bad++; $display("FAIL reset_bank z=%0d: got %h, expected 0", z, a_bank[z]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_write_read();
    set_idle();
    we_RF = 1'b1; A3 = 5'd5; WD3 = 26'h3FFFFFF;
    tick();
    set_idle();
    rd_en = 2'b01; rd_addr[0 +: AW] = 5'd5;
    tick();
    set_idle();
    n_cmp++;
    if (rd_data0[0 +: DW] !== 26'h3FFFFFF || rd_valid0[0] !== 1'b1) begin
      n_bad++; $display("FAIL write_read: got data %h valid %b, expected 3ffffff valid 1", rd_data0[0 +: DW], rd_valid0[0]);
    end
  endtask

  task automatic test_bypass();
    set_idle();
    we_RF = 1'b1; A3 = 5'd7; WD3 = 26'h00000AA;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    tick();
    set_idle();
    n_cmp++;
    if (rd_data0 !== {26'h00000AA, 26'h00000AA} || rd_valid0 !== 2'b11) begin
      n_bad++; $display("FAIL bypass: got data %h valid %b, expected 00000aa x2 valid 11", rd_data0, rd_valid0);
    end
  endtask

  task automatic test_claim();
    set_idle();
    claim_en = 1'b1; claim_addr = 5'd3;
    tick();
    set_idle();
    rd_en = 2'b01; rd_addr[0 +: AW] = 5'd3;
    tick();
    n_cmp++;
    if (rd_valid0[0] !== 1'b0 || busy0[3] !== 1'b1) begin
      n_bad++; $display("FAIL claim_stale: got valid %b busy3 %b, expected valid 0 busy3 1", rd_valid0[0], busy0[3]);
    end
    we_RF = 1'b1; A3 = 5'd3; WD3 = 26'h0000123;
    tick();
    set_idle();
    n_cmp++;
    if (rd_valid0[0] !== 1'b1 || rd_data0[0 +: DW] !== 26'h0000123 || busy0[3] !== 1'b0) begin
      n_bad++; $display("FAIL claim_release: got valid %b data %h busy3 %b, expected 1 0000123 0", rd_valid0[0], rd_data0[0 +: DW], busy0[3]);
    end
  endtask

  task automatic test_claim_write_same();
    set_idle();
    claim_en = 1'b1; claim_addr = 5'd4;
    we_RF = 1'b1; A3 = 5'd4; WD3 = 26'h0000444;
    tick();
    set_idle();
    n_cmp++;
    if (busy0[4] !== 1'b1 || bank0[4*DW +: DW] !== 26'h0000444) begin
      n_bad++; $display("FAIL claim_wins: got busy4 %b reg4 %h, expected busy4 1 reg4 0000444", busy0[4], bank0[4*DW +: DW]);
    end
    we_RF = 1'b1; A3 = 5'd4; WD3 = 26'h0000445;
    tick();
    set_idle();
  endtask

  task automatic test_oob_zero();
    logic [NR*DW-1:0] saved;
    set_idle();
    saved = bank0;
    we_RF = 1'b1; A3 = 5'd20; WD3 = 26'h0001234;
    tick();
    set_idle();
    n_cmp++;
    if (bank0 !== saved || err0 !== 1'b1) begin
      n_bad++; $display("FAIL oob_write: got err %b bank %h, expected err 1 bank %h", err0, bank0, saved);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (err0 !== 1'b1 || err1 !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: got %b/%b, expected 1/1", err0, err1);
    end
    we_RF = 1'b1; A3 = 5'd0; WD3 = 26'h0000055;
    tick();
    set_idle();
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    tick();
    set_idle();
    n_cmp++;
    if (rd_data1 !== '0 || rd_valid1 !== 2'b11 || bank1[0 +: DW] !== '0) begin
      n_bad++; $display("FAIL zero_reg: got data %h valid %b reg0 %h, expected 0 11 0", rd_data1, rd_valid1, bank1[0 +: DW]);
    end
    n_cmp++;
    if (rd_data0 !== {26'h0000055, 26'h0000055} || rd_valid0 !== 2'b11) begin
      n_bad++; $display("FAIL plain_reg0: got data %h valid %b, expected 0000055 x2 11", rd_data0, rd_valid0);
    end
  endtask

  task automatic test_random();
    logic [NP*DW-1:0] e_rd;
    logic [NP-1:0]    e_rv;
    logic [NR-1:0]    e_busy;
    logic [NR*DW-1:0] e_bank;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      we_RF      = ($urandom_range(0, 1) == 1);
      A3         = AW'($urandom_range(0, 14));
      WD3        = DW'($urandom);
      claim_en   = ($urandom_range(0, 2) == 0);
      claim_addr = AW'($urandom_range(0, 13));
      rd_en      = NP'($urandom);
      for (int i = 0; i < NP; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 13));
      tick();
      for (int z = 0; z < 2; z++) begin
        for (int i = 0; i < NP; i++) begin
          e_rd[i*DW +: DW] = m_rd[z][i];
          e_rv[i]          = m_rv[z][i];
        end
        for (int j = 0; j < NR; j++) begin
          e_busy[j]          = m_busy[z][j];
          e_bank[j*DW +: DW] = m_mem[z][j];
        end
        n_cmp++;
        if (a_rd[z] !== e_rd) begin
          n_bad++; $display("FAIL rand_rd_data z=%0d c=%0d: got %h expected %h", z, c, a_rd[z], e_rd);
        end
        n_cmp++;
        if (a_rv[z] !== e_rv) begin
          n_bad++; $display("FAIL rand_rd_valid z=%0d c=%0d: got %b expected %b", z, c, a_rv[z], e_rv);
        end
        n_cmp++;
        if (a_busy[z] !== e_busy) begin
          n_bad++; $display("FAIL rand_busy z=%0d c=%0d: got %h expected %h", z, c, a_busy[z], e_busy);
        end
        n_cmp++;
        if (a_err[z] !== m_err[z]) begin
          n_bad++; $display("FAIL rand_err z=%0d c=%0d: got %b expected %b", z, c, a_err[z], m_err[z]);
        end
        n_cmp++;
        if (a_bank[z] !== e_bank) begin
          n_bad++; $display("FAIL rand_bank z=%0d c=%0d: got %h expected %h", z, c, a_bank[z], e_bank);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    set_idle();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    we_RF = 1'b1; A3 = 5'd2; WD3 = 26'h0000077;
    claim_en = 1'b1; claim_addr = 5'd3;
    tick();
    set_idle();
    claim_en = 1'b1; claim_addr = 5'd4;
    rd_en = 2'b01; rd_addr[0 +: AW] = 5'd2;
    we_RF = 1'b1; A3 = 5'd20;
    tick();
    set_idle();
    n_cmp++;
    if (busy0 !== 13'h0018 || rd_data0[0 +: DW] !== 26'h0000077 || err0 !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset: got busy %h data %h err %b, expected 0018 0000077 1", busy0, rd_data0[0 +: DW], err0);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (rd_data0 !== '0 || rd_valid0 !== '0 || busy0 !== '0 || err0 !== 1'b0 || bank0 !== '0) begin
      n_bad++; $display("FAIL async_reset: got data %h valid %b busy %h err %b, expected all 0", rd_data0, rd_valid0, busy0, err0);
    end
    we_RF = 1'b1; A3 = 5'd9; WD3 = 26'h0000099;
    claim_en = 1'b1; claim_addr = 5'd6;
    #1 rst = 1'b1;
    tick();
    set_idle();
    n_cmp++;
    if (bank0[9*DW +: DW] !== 26'h0000099 || busy0 !== 13'h0040) begin
      n_bad++; $display("FAIL first_edge: got reg9 %h busy %h, expected 0000099 0040", bank0[9*DW +: DW], busy0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_claim();
    test_claim_write_same();
    test_oob_zero();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
